// File: rtl/jesd204_tx_pkg.sv
// Shared constants and state encoding for the JESD204B TX link-layer sequencer.
package jesd204_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config marker

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/jesd204_tx_ilas_octet.sv
// Per-octet character selection: CGS comma, ILAS framing/config, or user data.
module jesd204_tx_ilas_octet
  import jesd204_tx_pkg::*;
#(
  parameter int OCTETS_PER_MULTIFRAME = 32,
  parameter int MF_W                  = 2,
  parameter int IDX_W                 = 5
) (
  input  state_t           state,
  input  logic [MF_W-1:0]  mf_cnt,
  input  logic [IDX_W-1:0] octet_idx,
  input  logic [7:0]       config_octet,
  input  logic [7:0]       data_octet,
  output logic [7:0]       octet,
  output logic             is_k
);

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    octet = '0;
    is_k  = 1'b0;
    case (state)
      ST_CGS: begin
        octet = K28_5;
        is_k  = 1'b1;
      end
      ST_ILAS: begin
        octet = 8'(octet_idx);
        if (int'(octet_idx) == 0) begin
          octet = K28_0;
          is_k  = 1'b1;
        end else if (int'(octet_idx) == OCTETS_PER_MULTIFRAME - 1) begin
          octet = K28_3;
          is_k  = 1'b1;
        end else if (mf_cnt == MF_W'(1)) begin
          // Second multiframe carries /Q/ followed by the link configuration.
          if (int'(octet_idx) == 1) begin
            octet = K28_4;
            is_k  = 1'b1;
          end else if (int'(octet_idx) < 16) begin
            octet = config_octet;
          end
        end
      end
      ST_DATA: octet = data_octet;
      default: ;
    endcase
  end

endmodule

// File: rtl/jesd204_tx_link_seq.sv
// JESD204B TX link sequencer: CGS -> ILAS -> DATA, aligned to the local multiframe beat.
module jesd204_tx_link_seq
  import jesd204_tx_pkg::*;
#(
  parameter int NUM_LANES             = 1,
  parameter int DATA_PATH_WIDTH       = 4,
  parameter int OCTETS_PER_MULTIFRAME = 32,
  parameter int ILAS_MULTIFRAMES      = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   enable,
  input  logic                                   sync_n,
  input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] tx_data,
  output logic                                   tx_ready,
  input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] ilas_config_data,
  output logic [1:0]                             ilas_config_addr,
  output logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] char,
  output logic [NUM_LANES*DATA_PATH_WIDTH-1:0]   charisk,
  output logic [1:0]                             status_state
);

  localparam int BEATS_PER_MF = OCTETS_PER_MULTIFRAME / DATA_PATH_WIDTH;
  localparam int BEAT_W       = $clog2(BEATS_PER_MF);
  localparam int MF_W         = $clog2(ILAS_MULTIFRAMES);
  localparam int IDX_W        = $clog2(OCTETS_PER_MULTIFRAME);
  localparam int CFG_BEATS    = 16 / DATA_PATH_WIDTH;
  localparam int LANE_W       = DATA_PATH_WIDTH * 8;

  state_t            state, state_nx;
  logic [BEAT_W-1:0] lmfc_beat;
  logic [MF_W-1:0]   mf_cnt, mf_nx;
  logic              mf_end;

  logic [NUM_LANES*LANE_W-1:0]          char_nx;
  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] charisk_nx;
  logic [IDX_W-1:0]                     octet_idx [DATA_PATH_WIDTH];

  assign mf_end = (lmfc_beat == BEAT_W'(BEATS_PER_MF - 1));

  always_comb begin
    state_nx = state;
    mf_nx    = mf_cnt;
    if (!enable) begin
      state_nx = ST_IDLE;
      mf_nx    = '0;
    end else if (!sync_n && (state == ST_ILAS || state == ST_DATA)) begin
      state_nx = ST_CGS;
      mf_nx    = '0;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_CGS;
        ST_CGS:  if (sync_n && mf_end) state_nx = ST_ILAS;
        ST_ILAS: begin
          if (mf_end) begin
            if (mf_cnt == MF_W'(ILAS_MULTIFRAMES - 1)) begin
              state_nx = ST_DATA;
              mf_nx    = '0;
            end else begin
              mf_nx = mf_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      lmfc_beat <= '0;
      mf_cnt    <= '0;
      char      <= '0;
      charisk   <= '0;
    end else begin
      state     <= state_nx;
      lmfc_beat <= mf_end ? '0 : lmfc_beat + 1'b1;
      mf_cnt    <= mf_nx;
      char      <= char_nx;
      charisk   <= charisk_nx;
    end
  end

  assign tx_ready     = (state == ST_DATA);
  assign status_state = state;

  // Config beats are addressed only during the first 16 octets of multiframe 1.
  assign ilas_config_addr = (state == ST_ILAS && mf_cnt == MF_W'(1) && int'(lmfc_beat) < CFG_BEATS)
                          ? 2'(lmfc_beat) : 2'd0;

  for (genvar n = 0; n < DATA_PATH_WIDTH; n++) begin : g_idx
    assign octet_idx[n] = IDX_W'(32'(lmfc_beat) * DATA_PATH_WIDTH + n);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar n = 0; n < DATA_PATH_WIDTH; n++) begin : g_octet
      jesd204_tx_ilas_octet #(
        .OCTETS_PER_MULTIFRAME(OCTETS_PER_MULTIFRAME),
        .MF_W                 (MF_W),
        .IDX_W                (IDX_W)
      ) u_octet (
        .state       (state),
        .mf_cnt      (mf_cnt),
        .octet_idx   (octet_idx[n]),
        .config_octet(ilas_config_data[l*LANE_W + n*8 +: 8]),
        .data_octet  (tx_data[l*LANE_W + n*8 +: 8]),
        .octet       (char_nx[l*LANE_W + n*8 +: 8]),
        .is_k        (charisk_nx[l*DATA_PATH_WIDTH + n])
      );
    end
  end

endmodule

// File: tb/tb_jesd204_tx_link_seq.sv
// Directed bench for the JESD204B TX link sequencer (1 lane, 4 octets/beat, 8 beats/multiframe).
module tb_jesd204_tx_link_seq;

  localparam int BPM = 8;

  logic        clk = 1'b0;
  logic        resetn, enable, sync_n;
  logic [31:0] tx_data, ilas_config_data, char;
  logic [3:0]  charisk;
  logic        tx_ready;
  logic [1:0]  ilas_config_addr, status_state;

  int vectors = 0;
  int errors  = 0;
  int beat;

  always #5 clk = ~clk;

  jesd204_tx_link_seq dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .sync_n          (sync_n),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .ilas_config_data(ilas_config_data),
    .ilas_config_addr(ilas_config_addr),
    .char            (char),
    .charisk         (charisk),
    .status_state    (status_state)
  );

  // Config source: octet n of config beat a is 0xA0 + a*4 + n.
  always_comb begin
    ilas_config_data = '0;
    for (int n = 0; n < 4; n++)
      ilas_config_data[n*8 +: 8] = 8'(8'hA0 + 4 * int'(ilas_config_addr) + n);
  end

  // Reference multiframe beat counter.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) beat <= 0;
    else         beat <= (beat == BPM - 1) ? 0 : beat + 1;
  end

  // Expected {charisk, char} for ILAS multiframe mf, beat b.
  function automatic logic [35:0] exp_ilas(int mf, int b);
    logic [31:0] c;
    logic [3:0]  k;
    for (int n = 0; n < 4; n++) begin
      int idx = b * 4 + n;
      c[n*8 +: 8] = 8'(idx);
      k[n]        = 1'b0;
      if (idx == 0)                          begin c[n*8 +: 8] = 8'h1C; k[n] = 1'b1; end
      else if (idx == 31)                    begin c[n*8 +: 8] = 8'h7C; k[n] = 1'b1; end
      else if (mf == 1 && idx == 1)          begin c[n*8 +: 8] = 8'h9C; k[n] = 1'b1; end
      else if (mf == 1 && idx < 16)          c[n*8 +: 8] = 8'(8'hA0 + idx);
    end
    return {k, c};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; sync_n = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({char, charisk, tx_ready, status_state, ilas_config_addr} !== 41'd0) begin
      errors++;
      $display("FAIL reset_hold: char=%h charisk=%b ready=%b state=%0d addr=%0d, want all 0",
               char, charisk, tx_ready, status_state, ilas_config_addr);
    end
    resetn = 1'b1;
    step();
    vectors++;
    if ({char, charisk, tx_ready, status_state} !== 39'd0) begin
      errors++;
      $display("FAIL reset_release_idle: char=%h charisk=%b ready=%b state=%0d, want all 0",
               char, charisk, tx_ready, status_state);
    end
  endtask

  task automatic test_cgs();
    enable = 1'b1; sync_n = 1'b0;
    step();
    vectors++;
    if (status_state !== 2'd1 || tx_ready !== 1'b0 || {charisk, char} !== 36'd0) begin
      errors++;
      $display("FAIL cgs_enter: state=%0d ready=%b char=%h charisk=%b, want 1/0/0/0",
               status_state, tx_ready, char, charisk);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({charisk, char} !== {4'hF, 32'hBCBCBCBC} || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL cgs_stream[%0d]: char=%h charisk=%b ready=%b, want bcbcbcbc/1111/0",
                 i, char, charisk, tx_ready);
      end
    end
  endtask

  task automatic test_ilas_entry();
    for (int i = 0; i < BPM && beat != 2; i++) step();
    vectors++;
    if (beat != 2) begin
      errors++;
      $display("FAIL ilas_entry_align: beat=%0d, want 2", beat);
    end
    sync_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if ({charisk, char} !== {4'hF, 32'hBCBCBCBC} || status_state !== ((i == 5) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL cgs_until_beat7[%0d]: char=%h charisk=%b state=%0d, want bcbcbcbc/1111/%0d",
                 i, char, charisk, status_state, (i == 5) ? 2 : 1);
      end
    end
  endtask

  task automatic test_ilas_contents();
    logic [35:0] e;
    tx_data = 32'h03020100;
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < BPM; b++) begin
        vectors++;
        if (ilas_config_addr !== ((m == 1 && b < 4) ? 2'(b) : 2'd0) || tx_ready !== 1'b0 ||
            status_state !== 2'd2) begin
          errors++;
          $display("FAIL ilas_ctrl mf%0d b%0d: addr=%0d ready=%b state=%0d, want %0d/0/2",
                   m, b, ilas_config_addr, tx_ready, status_state, (m == 1 && b < 4) ? b : 0);
        end
        step();
        e = exp_ilas(m, b);
        vectors++;
        if ({charisk, char} !== e) begin
          errors++;
          $display("FAIL ilas_octets mf%0d b%0d: char=%h charisk=%b, want %h/%b",
                   m, b, char, charisk, e[31:0], e[35:32]);
        end
      end
    end
    vectors++;
    if (tx_ready !== 1'b1 || status_state !== 2'd3) begin
      errors++;
      $display("FAIL ilas_length: ready=%b state=%0d after 32 beats, want 1/3", tx_ready, status_state);
    end
  endtask

  task automatic test_data();
    logic [31:0] words [3] = '{32'h03020100, 32'hDEADBEEF, 32'h5A5AA5A5};
    for (int i = 0; i < 3; i++) begin
      tx_data = words[i];
      step();
      vectors++;
      if ({charisk, char} !== {4'h0, words[i]} || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL data_pass[%0d]: char=%h charisk=%b ready=%b, want %h/0000/1",
                 i, char, charisk, tx_ready, words[i]);
      end
    end
  endtask

  task automatic test_sync_abort();
    sync_n = 1'b0; tx_data = 32'h11223344;
    step();
    vectors++;
    if (status_state !== 2'd1 || tx_ready !== 1'b0 || {charisk, char} !== {4'h0, 32'h11223344}) begin
      errors++;
      $display("FAIL data_abort_1: state=%0d ready=%b char=%h charisk=%b, want 1/0/11223344/0000",
               status_state, tx_ready, char, charisk);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({charisk, char} !== {4'hF, 32'hBCBCBCBC} || status_state !== 2'd1) begin
        errors++;
        $display("FAIL data_abort_cgs[%0d]: char=%h charisk=%b state=%0d, want bcbcbcbc/1111/1",
                 i, char, charisk, status_state);
      end
    end
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    step();
    vectors++;
    if (status_state !== 2'd0 || {charisk, char} !== {4'hF, 32'hBCBCBCBC}) begin
      errors++;
      $display("FAIL disable_1: state=%0d char=%h charisk=%b, want 0/bcbcbcbc/1111",
               status_state, char, charisk);
    end
    step();
    vectors++;
    if ({charisk, char} !== 36'd0 || ilas_config_addr !== 2'd0) begin
      errors++;
      $display("FAIL disable_zero: char=%h charisk=%b addr=%0d, want 0/0/0", char, charisk, ilas_config_addr);
    end
  endtask

  task automatic wait_ilas(input string name);
    for (int i = 0; i < 40 && status_state != 2'd2; i++) step();
    vectors++;
    if (status_state !== 2'd2) begin
      errors++;
      $display("FAIL %s: timeout, state=%0d want 2", name, status_state);
    end
  endtask

  task automatic test_ilas_abort();
    enable = 1'b1; sync_n = 1'b1;
    wait_ilas("wait_ilas_1");
    repeat (10) step();
    vectors++;
    if (ilas_config_addr !== 2'd2 || {charisk, char} !== {4'h0, 32'hA7A6A5A4}) begin
      errors++;
      $display("FAIL ilas_mf1_b1: addr=%0d char=%h charisk=%b, want 2/a7a6a5a4/0000",
               ilas_config_addr, char, charisk);
    end
    sync_n = 1'b0;
    step();
    vectors++;
    if (status_state !== 2'd1 || {charisk, char} !== {4'h0, 32'hABAAA9A8}) begin
      errors++;
      $display("FAIL ilas_abort_1: state=%0d char=%h charisk=%b, want 1/abaaa9a8/0000",
               status_state, char, charisk);
    end
    step();
    vectors++;
    if ({charisk, char} !== {4'hF, 32'hBCBCBCBC}) begin
      errors++;
      $display("FAIL ilas_abort_2: char=%h charisk=%b, want bcbcbcbc/1111", char, charisk);
    end
    sync_n = 1'b1;
    wait_ilas("wait_ilas_2");
    step();
    vectors++;
    if ({charisk, char} !== {4'b0001, 32'h0302011C}) begin
      errors++;
      $display("FAIL reentry_mf0: char=%h charisk=%b, want 0302011c/0001", char, charisk);
    end
  endtask

  task automatic test_reset_mid_ilas();
    repeat (3) step();
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if ({char, charisk, tx_ready, status_state, ilas_config_addr} !== 41'd0) begin
      errors++;
      $display("FAIL async_reset: char=%h charisk=%b ready=%b state=%0d addr=%0d, want all 0",
               char, charisk, tx_ready, status_state, ilas_config_addr);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
    vectors++;
    if (status_state !== 2'd1 || {charisk, char} !== 36'd0) begin
      errors++;
      $display("FAIL post_reset_cgs: state=%0d char=%h charisk=%b, want 1/0/0", status_state, char, charisk);
    end
  endtask

  initial begin
    test_reset();
    test_cgs();
    test_ilas_entry();
    test_ilas_contents();
    test_data();
    test_sync_abort();
    test_enable_off();
    test_ilas_abort();
    test_reset_mid_ilas();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
